branch_resolver: RTL and testbench
==================================

# branch_resolver

Multi-cycle controller that resolves RV32IM conditional branches (opcode 1100011). It accepts a raw 32-bit instruction plus its PC and slices the B-type fields (opcode, rs1, rs2, funct3, scattered immediate). It then requests both source operands from a shared register-file read port, evaluates the funct3 condition, and returns a taken flag, target and next PC over a valid/ready handshake. It sits between decode and the PC-select logic in the execute stage.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of any in-flight branch.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept an instruction; high only in IDLE and rst=0.
- in_ins  in  32  raw instruction word.
- in_pc  in  32  PC of in_ins.
- rf_req  out  1  request for the shared register-file read port.
- rf_gnt  in  1  grant; rf_rs1_data and rf_rs2_data are valid in the same cycle.
- rf_rs1_addr  out  5  ins[19:15], held stable while rf_req=1.
- rf_rs2_addr  out  5  ins[24:20], held stable while rf_req=1.
- rf_rs1_data  in  32  rs1 operand.
- rf_rs2_data  in  32  rs2 operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  branch condition true.
- out_target  out  32  in_pc + sext(imm).
- out_next_pc  out  32  out_taken ? out_target : in_pc+4.
- out_illegal  out  1  opcode not 1100011, or funct3 is 010 or 011.
- out_misaligned  out  1  taken target not 4-byte aligned (see Configuration).

## Operation
- States: IDLE, RF_REQ, CMP, RESP.
- IDLE: on in_valid&in_ready, register ins and pc.
  - If the instruction is illegal, go to RESP. out_illegal=1, out_taken=0, out_next_pc=pc+4.
  - Otherwise go to RF_REQ.
- RF_REQ: rf_req=1. On rf_gnt, capture both operands and go to CMP. Wait indefinitely otherwise.
- CMP: evaluate the condition, register all results, go to RESP.
  - 000 BEQ: a==b.
  - 001 BNE: a!=b.
  - 100 BLT: signed a<b.
  - 101 BGE: signed a>=b.
  - 110 BLTU: unsigned a<b.
  - 111 BGEU: unsigned a>=b.
- RESP: out_valid=1, with outputs stable until out_valid&out_ready, then go to IDLE.
- Immediate: {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, a 13-bit value sign-extended to 32 bits.
- Arithmetic: target and pc+4 are computed modulo 2^32; wrap-around is silent.
- flush has priority over every transition.
  - Next cycle: state=IDLE, rf_req=0, out_valid=0.
  - A grant arriving in the flush cycle is ignored.
  - A result offered in the flush cycle is dropped, even if out_ready=1.
- rst has the same effect as flush.
  - Reset values: all outputs 0, including in_ready while rst=1.
  - in_ready rises the cycle after rst deasserts.

## Timing
- Accept at cycle T. rf_req is high from T+1.
- Grant at cycle G (G≥T+1): CMP at G+1, out_valid at G+2.
- Minimum legal latency, accept to out_valid: 3 cycles.
- Illegal instruction: out_valid at T+1; no rf_req is issued.
- No pipelining: at most one branch in flight. in_ready=0 from T+1 until the cycle after the output handshake.
- Back-to-back: a result taken at cycle R allows a new accept at R+1.
- rf_req deasserts in the cycle after rf_gnt.

## Configuration
- BRANCH_MISALIGN_TRAP_EN defined:
  - out_misaligned=1 when out_taken=1 and out_target[1]=1.
  - out_taken, out_target and out_next_pc are unchanged; the consumer raises the trap.
- BRANCH_MISALIGN_TRAP_EN undefined: out_misaligned is tied 0 and the check logic is not compiled.

## Test plan
- BEQ x1,x2,+8 at pc=0x100, rs1=rs2=5, grant immediately:
  - out_valid 3 cycles after accept.
  - taken=1, target=0x108, next_pc=0x108.
- BLT at pc=0x200, imm=-16, rs1=0xFFFFFFFF, rs2=1:
  - taken=1, target=0x1F0.
  - The same operands with BLTU give taken=0, next_pc=0x204.
- funct3=010, or opcode 0110011:
  - out_illegal=1, out_valid 1 cycle after accept.
  - rf_req never asserts; next_pc=pc+4.
- Grant withheld 5 cycles, then out_ready held low 3 cycles:
  - rf_req stays high with stable addresses.
  - Outputs stay stable throughout; in_ready=0 until the cycle after the handshake.
- flush asserted in the RF_REQ cycle, and separately in RESP:
  - Next cycle: IDLE, rf_req=0, out_valid=0.
  - A new instruction is accepted the following cycle and resolves correctly.
- With BRANCH_MISALIGN_TRAP_EN, BNE taken at pc=0x0 with imm=+6:
  - target=0x6, out_misaligned=1.
  - A not-taken case gives out_misaligned=0.

Source files
------------

// File: rtl/branch_resolver.sv
// Purpose : resolves one RV32 conditional branch (B-type) per transaction: slices the
//           fields, fetches rs1/rs2 through a shared register-file read port, evaluates
//           funct3, and returns taken / target / next PC.
// Latency : accept -> out_valid is 3 cycles with an immediate grant (+1 per withheld
//           grant cycle); an illegal instruction responds 1 cycle after accept.
// Backpressure: one branch in flight; in_ready stays low from accept until the cycle
//           after the out_valid/out_ready handshake, and the result is held stable meanwhile.
//
// Ports:
//   clk, rst (sync, active-high), flush (sync abort of the in-flight branch)
//   in_valid/in_ready/in_ins/in_pc       : instruction input handshake
//   rf_req/rf_gnt/rf_rs*_addr/rf_rs*_data : shared register-file read port
//   out_valid/out_ready/out_*            : result handshake
// Optional feature: define BRANCH_MISALIGN_TRAP_EN to flag taken targets with bit 1 set
// on out_misaligned; otherwise out_misaligned is tied low.

module branch_resolver #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_pc,
    output logic            rf_req,
    input  logic            rf_gnt,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_illegal,
    output logic            out_misaligned
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RF_REQ = 2'd1,
        S_CMP    = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t state_q, state_d;

    // Fields and precomputed addresses captured at accept time.
    logic [2:0]      funct3_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            taken_q;
    logic [XLEN-1:0] next_pc_q;
    logic            illegal_q;
`ifdef BRANCH_MISALIGN_TRAP_EN
    logic            misaligned_q;
`endif

    // ------------------------------------------------------------------
    // Incoming instruction decode
    // ------------------------------------------------------------------
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_imm;
    logic            in_illegal;

    always_comb begin
        in_opcode  = in_ins[6:0];
        in_funct3  = in_ins[14:12];
        // B-type immediate is scattered; bit 0 is always zero.
        in_imm     = {{(XLEN-13){in_ins[31]}}, in_ins[31], in_ins[7],
                      in_ins[30:25], in_ins[11:8], 1'b0};
        // funct3 010/011 are unassigned in the branch opcode space.
        in_illegal = (in_opcode != OPC_BRANCH) || (in_funct3[2:1] == 2'b01);
    end

    // ------------------------------------------------------------------
    // Condition evaluation on captured operands
    // ------------------------------------------------------------------
    logic cond_taken;

    always_comb begin
        cond_taken = 1'b0;
        case (funct3_q)
            3'b000:  cond_taken = (a_q == b_q);
            3'b001:  cond_taken = (a_q != b_q);
            3'b100:  cond_taken = ($signed(a_q) <  $signed(b_q));
            3'b101:  cond_taken = ($signed(a_q) >= $signed(b_q));
            3'b110:  cond_taken = (a_q <  b_q);
            3'b111:  cond_taken = (a_q >= b_q);
            default: cond_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (flush overrides every transition)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_illegal ? S_RESP : S_RF_REQ;
                end
            end
            S_RF_REQ: begin
                if (rf_gnt) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers. Nothing is captured in a flush cycle, so a grant
    // or accept coinciding with flush leaves no trace.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q     <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            target_q     <= '0;
            pc4_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            taken_q      <= 1'b0;
            next_pc_q    <= '0;
            illegal_q    <= 1'b0;
`ifdef BRANCH_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else if (!flush) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        funct3_q     <= in_funct3;
                        rs1_q        <= in_ins[19:15];
                        rs2_q        <= in_ins[24:20];
                        // Both candidate PCs are formed up front; wrap is silent.
                        target_q     <= in_pc + in_imm;
                        pc4_q        <= in_pc + XLEN'(4);
                        illegal_q    <= in_illegal;
                        // Illegal instructions respond directly with these values.
                        taken_q      <= 1'b0;
                        next_pc_q    <= in_pc + XLEN'(4);
`ifdef BRANCH_MISALIGN_TRAP_EN
                        misaligned_q <= 1'b0;
`endif
                    end
                end
                S_RF_REQ: begin
                    if (rf_gnt) begin
                        a_q <= rf_rs1_data;
                        b_q <= rf_rs2_data;
                    end
                end
                S_CMP: begin
                    taken_q      <= cond_taken;
                    next_pc_q    <= cond_taken ? target_q : pc4_q;
`ifdef BRANCH_MISALIGN_TRAP_EN
                    misaligned_q <= cond_taken && target_q[1];
`endif
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Everything reads zero while rst is held.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready       = 1'b0;
        rf_req         = 1'b0;
        rf_rs1_addr    = '0;
        rf_rs2_addr    = '0;
        out_valid      = 1'b0;
        out_taken      = 1'b0;
        out_target     = '0;
        out_next_pc    = '0;
        out_illegal    = 1'b0;
        out_misaligned = 1'b0;
        if (!rst) begin
            in_ready       = (state_q == S_IDLE);
            rf_req         = (state_q == S_RF_REQ);
            rf_rs1_addr    = rs1_q;
            rf_rs2_addr    = rs2_q;
            out_valid      = (state_q == S_RESP);
            out_taken      = taken_q;
            out_target     = target_q;
            out_next_pc    = next_pc_q;
            out_illegal    = illegal_q;
`ifdef BRANCH_MISALIGN_TRAP_EN
            out_misaligned = misaligned_q;
`endif
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Purpose : directed bench for branch_resolver with a queue-based scoreboard; the
//           stimulus process pushes hand-computed results, a negedge monitor pops and
//           compares on every output handshake.
// Ports   : drives every DUT input; 10 ns clock.

module tb_branch_resolver;

`ifdef BRANCH_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ins;
    logic [31:0] in_pc;
    logic        rf_req;
    logic        rf_gnt;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] out_next_pc;
    logic        out_illegal;
    logic        out_misaligned;

    branch_resolver #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ins         (in_ins),
        .in_pc          (in_pc),
        .rf_req         (rf_req),
        .rf_gnt         (rf_gnt),
        .rf_rs1_addr    (rf_rs1_addr),
        .rf_rs2_addr    (rf_rs2_addr),
        .rf_rs1_data    (rf_rs1_data),
        .rf_rs2_data    (rf_rs2_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_next_pc    (out_next_pc),
        .out_illegal    (out_illegal),
        .out_misaligned (out_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        illegal;
        logic        taken;
        logic        mis;
        logic [31:0] target;
        logic [31:0] next_pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // B-type encoder: imm is the 13-bit byte offset (bit 0 dropped).
    function automatic logic [31:0] mk_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Monitor: a handshake at the coming edge consumes one expected result.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got target %h with no expected entry", out_target);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_illegal",    32'(out_illegal),    32'(mon_e.illegal));
                chk("sb_taken",      32'(out_taken),      32'(mon_e.taken));
                chk("sb_target",     out_target,          mon_e.target);
                chk("sb_next_pc",    out_next_pc,         mon_e.next_pc);
                chk("sb_misaligned", 32'(out_misaligned), 32'(mon_e.mis));
            end
        end
    end

    // One full transaction. Entered and left at posedge+1 with the DUT idle.
    task automatic run_br(input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b,
                          input int gnt_dly, input int rdy_dly,
                          input logic ill, input logic tk,
                          input logic [31:0] tgt, input logic [31:0] npc,
                          input logic mis_en);
        exp_t e;
        e.illegal = ill;
        e.taken   = tk;
        e.target  = tgt;
        e.next_pc = npc;
        e.mis     = mis_en & MIS_EN;
        sb.push_back(e);

        in_ins   = ins;
        in_pc    = pc;
        in_valid = 1'b1;
        @(negedge clk);
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_ins   = 32'hFFFF_FFFF;
        in_pc    = 32'hFFFF_FFFF;

        if (!ill) begin
            rf_gnt      = 1'b0;
            rf_rs1_data = 32'hBAD0_BAD0;
            rf_rs2_data = 32'h0BAD_0BAD;
            for (int i = 0; i < gnt_dly; i++) begin
                @(negedge clk);
                chk("wait_rf_req",   32'(rf_req),      32'd1);
                chk("wait_rs1_addr", 32'(rf_rs1_addr), 32'(ins[19:15]));
                chk("wait_rs2_addr", 32'(rf_rs2_addr), 32'(ins[24:20]));
                chk("wait_in_ready", 32'(in_ready),    32'd0);
                @(posedge clk); #1;
            end
            rf_gnt      = 1'b1;
            rf_rs1_data = a;
            rf_rs2_data = b;
            @(negedge clk);
            chk("gnt_rf_req",   32'(rf_req),      32'd1);
            chk("gnt_rs1_addr", 32'(rf_rs1_addr), 32'(ins[19:15]));
            chk("gnt_valid",    32'(out_valid),   32'd0);
            @(posedge clk); #1;
            rf_gnt      = 1'b0;
            rf_rs1_data = 32'hBAD0_BAD0;
            rf_rs2_data = 32'h0BAD_0BAD;
            @(negedge clk);
            chk("cmp_rf_req", 32'(rf_req),    32'd0);
            chk("cmp_valid",  32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < rdy_dly; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
            chk("hold_taken",    32'(out_taken), 32'(tk));
            chk("hold_target",   out_target,     tgt);
            chk("hold_next_pc",  out_next_pc,    npc);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("resp_valid",  32'(out_valid), 32'd1);
        chk("resp_rf_req", 32'(rf_req),    32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_in_ready", 32'(in_ready),  32'd1);
        chk("post_valid",    32'(out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_ins      = '0;
        in_pc       = '0;
        rf_gnt      = 1'b0;
        rf_rs1_data = '0;
        rf_rs2_data = '0;
        out_ready   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),    32'd0);
        chk("rst_rf_req",    32'(rf_req),      32'd0);
        chk("rst_valid",     32'(out_valid),   32'd0);
        chk("rst_taken",     32'(out_taken),   32'd0);
        chk("rst_target",    out_target,       32'd0);
        chk("rst_next_pc",   out_next_pc,      32'd0);
        chk("rst_illegal",   32'(out_illegal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // BEQ x1,x2,+8 @0x100, equal operands, immediate grant
        run_br(mk_b(13'd8, 5'd2, 5'd1, 3'b000), 32'h100, 32'd5, 32'd5, 0, 0,
               1'b0, 1'b1, 32'h108, 32'h108, 1'b0);
        // BLT -16 @0x200: -1 < 1 signed
        run_br(mk_b(13'h1FF0, 5'd2, 5'd1, 3'b100), 32'h200, 32'hFFFF_FFFF, 32'd1, 0, 0,
               1'b0, 1'b1, 32'h1F0, 32'h1F0, 1'b0);
        // BLTU same operands: 0xFFFFFFFF < 1 unsigned is false
        run_br(mk_b(13'h1FF0, 5'd2, 5'd1, 3'b110), 32'h200, 32'hFFFF_FFFF, 32'd1, 0, 0,
               1'b0, 1'b0, 32'h1F0, 32'h204, 1'b0);
        // BLT not taken: 1 < -1 signed is false
        run_br(mk_b(13'h040, 5'd17, 5'd31, 3'b100), 32'h800, 32'd1, 32'hFFFF_FFFF, 0, 0,
               1'b0, 1'b0, 32'h840, 32'h804, 1'b0);
        // funct3=010 is illegal
        run_br(mk_b(13'd8, 5'd2, 5'd1, 3'b010), 32'h300, 32'd0, 32'd0, 0, 0,
               1'b1, 1'b0, 32'h308, 32'h304, 1'b0);
        // add x3,x1,x2 (opcode 0110011): imm slice gives 0x802
        run_br(32'h0020_81B3, 32'h400, 32'd0, 32'd0, 0, 1,
               1'b1, 1'b0, 32'hC02, 32'h404, 1'b0);
        // BGE, grant withheld 5 cycles, out_ready low 3 cycles: 3 >= -2
        run_br(mk_b(13'h020, 5'd9, 5'd20, 3'b101), 32'h500, 32'd3, 32'hFFFF_FFFE, 5, 3,
               1'b0, 1'b1, 32'h520, 32'h520, 1'b0);
        // BGEU same operands: 3 >= 0xFFFFFFFE unsigned is false
        run_br(mk_b(13'h020, 5'd9, 5'd20, 3'b111), 32'h500, 32'd3, 32'hFFFF_FFFE, 2, 1,
               1'b0, 1'b0, 32'h520, 32'h504, 1'b0);
        // Wrap-around of target and pc+4
        run_br(mk_b(13'd8, 5'd2, 5'd1, 3'b001), 32'hFFFF_FFFC, 32'd1, 32'd2, 0, 0,
               1'b0, 1'b1, 32'h4, 32'h4, 1'b0);
        run_br(mk_b(13'd8, 5'd2, 5'd1, 3'b000), 32'hFFFF_FFFC, 32'd1, 32'd2, 0, 0,
               1'b0, 1'b0, 32'h4, 32'h0, 1'b0);
        // Most negative offset, -4096
        run_br(mk_b(13'h1000, 5'd0, 5'd0, 3'b000), 32'h2000, 32'd0, 32'd0, 1, 0,
               1'b0, 1'b1, 32'h1000, 32'h1000, 1'b0);

        // flush in RF_REQ together with a grant
        in_ins   = mk_b(13'd8, 5'd2, 5'd1, 3'b000);
        in_pc    = 32'h900;
        in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        flush       = 1'b1;
        rf_gnt      = 1'b1;
        rf_rs1_data = 32'd4;
        rf_rs2_data = 32'd4;
        @(negedge clk);
        chk("flreq_rf_req", 32'(rf_req), 32'd1);
        @(posedge clk); #1;
        flush  = 1'b0;
        rf_gnt = 1'b0;
        @(negedge clk);
        chk("flreq_after_rf_req",   32'(rf_req),    32'd0);
        chk("flreq_after_valid",    32'(out_valid), 32'd0);
        chk("flreq_after_in_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        run_br(mk_b(13'h010, 5'd4, 5'd3, 3'b000), 32'h600, 32'd7, 32'd7, 0, 0,
               1'b0, 1'b1, 32'h610, 32'h610, 1'b0);

        // flush in RESP with out_ready=1: result dropped
        in_ins   = mk_b(13'd8, 5'd2, 5'd1, 3'b001);
        in_pc    = 32'hA00;
        in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        rf_gnt      = 1'b1;
        rf_rs1_data = 32'd1;
        rf_rs2_data = 32'd2;
        @(posedge clk); #1;
        rf_gnt = 1'b0;
        @(posedge clk); #1;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flresp_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("flresp_after_valid",    32'(out_valid), 32'd0);
        chk("flresp_after_in_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        run_br(mk_b(13'h1FF8, 5'd6, 5'd5, 3'b001), 32'h700, 32'd1, 32'd0, 0, 0,
               1'b0, 1'b1, 32'h6F8, 32'h6F8, 1'b0);

        // Misaligned taken target (flagged only when the trap check is built)
        run_br(mk_b(13'd6, 5'd2, 5'd1, 3'b001), 32'h0, 32'd1, 32'd2, 0, 0,
               1'b0, 1'b1, 32'h6, 32'h6, 1'b1);
        run_br(mk_b(13'd6, 5'd2, 5'd1, 3'b001), 32'h0, 32'd9, 32'd9, 0, 0,
               1'b0, 1'b0, 32'h6, 32'h4, 1'b0);

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
